// File: rtl/svfloat_pkg.sv
// Shared svfloat types: float formats, exception flag bundle, leading-zero count.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package svfloat;

   // IEEE-754 binary32 layout.
   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] man;
   } float32;

   // IEEE-754 binary64 layout.
   typedef struct packed {
      logic        sign;
      logic [10:0] exp;
      logic [51:0] man;
   } float64;

   // Exception flags in the usual IEEE order.
   typedef struct packed {
      logic invalid;
      logic divzero;
      logic overflow;
      logic underflow;
      logic inexact;
   } fflags_t;

   // Width of the lzc input. Callers left-align shorter vectors and zero-pad.
   localparam int LZC_W = 64;

   // Leading-zero count of a left-aligned vector; all-zero input returns LZC_W.
   function automatic logic [6:0] lzc(input logic [LZC_W-1:0] v);
      lzc = 7'(LZC_W);
      for (int i = 0; i < LZC_W; i++) begin
         if (v[i]) lzc = 7'(LZC_W - 1 - i);
      end
   endfunction

endpackage

// File: rtl/svfloat_neg.sv
// Conditional sign flip of a float; NaNs may be passed through untouched.
// Latency: combinational.
// Backpressure: none (no state).
//
// Ports:
//   val        operand
//   neg        1 = flip the sign
//   presv_nan  1 = leave NaN operands exactly as they are
//   res        result
module svfloat_neg #(
   parameter type float = svfloat::float32
) (
   input  float val,
   input  logic neg,
   input  logic presv_nan,
   output float res
);

   logic is_nan;

   always_comb begin
      is_nan = (&val.exp) & (|val.man);
      res    = val;
      if (neg && !(presv_nan && is_nan)) begin
         res.sign = ~val.sign;
      end
   end

endmodule

// File: rtl/svfloat_addsub.sv
// Floating-point add/subtract, round-to-nearest-even, full-throughput pipeline.
// Latency: 3 stages (align, add, normalise/round); result valid on the third edge.
// Backpressure: one global stall, in_ready = !out_valid || out_ready; all stages hold.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, sub)
//   sub                 1 = a - b, 0 = a + b
//   out_valid/out_ready result handshake (res, flags)
//   flags               {invalid, divzero, overflow, underflow, inexact};
//                       exists only when SVFLOAT_ADDSUB_FLAGS_EN is defined
module svfloat_addsub
   import svfloat::*;
#(
   parameter type float = svfloat::float32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  float       a,
   input  float       b,
   input  logic       sub,
   output logic       out_valid,
   input  logic       out_ready,
   output float       res
`ifdef SVFLOAT_ADDSUB_FLAGS_EN
   ,
   output logic [4:0] flags
`endif
);

   localparam int EW = $bits(a.exp);
   localparam int MW = $bits(a.man);
   localparam int GW = MW + 4;      // hidden + mantissa + guard/round/sticky
   localparam int SW = MW + 5;      // GW plus carry-out
   localparam int XE = EW + 2;      // working exponent with headroom for carries

   localparam logic [XE-1:0] ONE     = XE'(1);
   localparam logic [XE-1:0] SH_MAX  = XE'(MW + 3);
   localparam logic [XE-1:0] EXP_INF = XE'((1 << EW) - 1);

   typedef struct packed {
      logic          sign;
      logic          eff_sub;
      logic [XE-1:0] exp;
      logic [GW-1:0] xm;
      logic [GW-1:0] ym;
      logic          spec;
      float          sp_res;
   } s1_t;

   typedef struct packed {
      logic          sign;
      logic          eff_sub;
      logic [XE-1:0] exp;
      logic [SW-1:0] sum;
      logic          spec;
      float          sp_res;
   } s2_t;

   logic en;
   logic s1_vld, s2_vld;
   s1_t  s1_d, s1_q;
   s2_t  s2_d, s2_q;
   float s3_res;

   assign en       = ~out_valid | out_ready;
   assign in_ready = en;

   // Subtraction is addition of a sign-flipped b; NaN payloads are left alone.
   float b_n;

   svfloat_neg #(.float(float)) u_neg_b (
      .val       (b),
      .neg       (sub),
      .presv_nan (1'b1),
      .res       (b_n)
   );

   // ---------------- S1: classify, swap, align ----------------
   logic            a_nan, b_nan, a_inf, b_inf, inf_clash, swap;
   logic            x_sign;
   logic [EW-1:0]   x_exp, y_exp;
   logic [MW-1:0]   x_man, y_man;
   logic [XE-1:0]   ex, ey, diff, sh1;
   logic [MW:0]     xs, ys;
   logic [2*GW-1:0] yw;
   float            qnan;

   always_comb begin
      a_nan     = (&a.exp) & (|a.man);
      a_inf     = (&a.exp) & ~(|a.man);
      b_nan     = (&b_n.exp) & (|b_n.man);
      b_inf     = (&b_n.exp) & ~(|b_n.man);
      inf_clash = a_inf & b_inf & (a.sign ^ b_n.sign);

      qnan            = '0;
      qnan.exp        = '1;
      qnan.man[MW-1]  = 1'b1;

      // Magnitude compare on {exp, man} orders both normals and subnormals.
      swap   = {b_n.exp, b_n.man} > {a.exp, a.man};
      x_sign = swap ? b_n.sign : a.sign;
      x_exp  = swap ? b_n.exp  : a.exp;
      x_man  = swap ? b_n.man  : a.man;
      y_exp  = swap ? a.exp    : b_n.exp;
      y_man  = swap ? a.man    : b_n.man;

      // Subnormals: effective exponent 1, hidden bit 0.
      ex = (x_exp == '0) ? ONE : XE'(x_exp);
      ey = (y_exp == '0) ? ONE : XE'(y_exp);
      xs = {|x_exp, x_man};
      ys = {|y_exp, y_man};

      diff = ex - ey;
      sh1  = (diff > SH_MAX) ? SH_MAX : diff;

      // Shift into a double-width window; the lower half collapses into sticky.
      yw = {ys, 3'b000, {GW{1'b0}}} >> sh1;

      s1_d         = '0;
      s1_d.sign    = x_sign;
      s1_d.eff_sub = a.sign ^ b_n.sign;
      s1_d.exp     = ex;
      s1_d.xm      = {xs, 3'b000};
      s1_d.ym      = {yw[2*GW-1:GW+1], yw[GW] | (|yw[GW-1:0])};
      s1_d.spec    = a_nan | b_nan | a_inf | b_inf;
      if (a_nan | b_nan | inf_clash) begin
         s1_d.sp_res = qnan;
      end else if (a_inf) begin
         s1_d.sp_res = a;
      end else begin
         s1_d.sp_res = b_n;
      end
   end

   // ---------------- S2: add / subtract magnitudes ----------------
   always_comb begin
      s2_d         = '0;
      s2_d.sign    = s1_q.sign;
      s2_d.eff_sub = s1_q.eff_sub;
      s2_d.exp     = s1_q.exp;
      s2_d.spec    = s1_q.spec;
      s2_d.sp_res  = s1_q.sp_res;
      // x >= y in magnitude, so the difference never wraps.
      s2_d.sum     = s1_q.eff_sub ? ({1'b0, s1_q.xm} - {1'b0, s1_q.ym})
                                  : ({1'b0, s1_q.xm} + {1'b0, s1_q.ym});
   end

   // ---------------- S3: normalise, round, pack ----------------
   logic [LZC_W-1:0] lz_in;
   logic [6:0]       lz;
   logic [XE-1:0]    lim, sh3, ne, fe;
   logic [GW-1:0]    nm;
   logic [MW+1:0]    rm;
   logic [MW-1:0]    fman;
   logic             rup, sum_zero, ovf;

   always_comb begin
      sum_zero = ~(|s2_q.sum);
      lz_in    = {s2_q.sum[SW-2:0], {(LZC_W - SW + 1){1'b0}}};
      lz       = lzc(lz_in);
      // Never normalise below exponent 1; what remains is a subnormal.
      lim      = s2_q.exp - ONE;
      sh3      = (XE'(lz) > lim) ? lim : XE'(lz);

      if (s2_q.sum[SW-1]) begin
         nm = {s2_q.sum[SW-1:2], |s2_q.sum[1:0]};
         ne = s2_q.exp + ONE;
      end else begin
         nm = s2_q.sum[SW-2:0] << sh3;
         ne = s2_q.exp - sh3;
      end

      // nm = {hidden, mantissa, guard, round, sticky}
      rup = nm[2] & (nm[1] | nm[0] | nm[3]);
      rm  = {1'b0, nm[GW-1:3]} + {{(MW+1){1'b0}}, rup};

      if (rm[MW+1]) begin
         fman = rm[MW:1];
         fe   = ne + ONE;
      end else begin
         fman = rm[MW-1:0];
         // No hidden bit after rounding means the result is subnormal or zero.
         fe   = rm[MW] ? ne : '0;
      end
      ovf = (fe >= EXP_INF);

      s3_res = '0;
      if (s2_q.spec) begin
         s3_res = s2_q.sp_res;
      end else if (ovf) begin
         s3_res.sign = s2_q.sign;
         s3_res.exp  = '1;
      end else begin
         // Exact zero from opposite signs is +0; same-signed zeros keep their sign.
         s3_res.sign = sum_zero ? (s2_q.sign & ~s2_q.eff_sub) : s2_q.sign;
         s3_res.exp  = fe[EW-1:0];
         s3_res.man  = fman;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld    <= 1'b0;
         s2_vld    <= 1'b0;
         out_valid <= 1'b0;
         s1_q      <= '0;
         s2_q      <= '0;
         res       <= '0;
      end else if (en) begin
         s1_vld    <= in_valid;
         s1_q      <= s1_d;
         s2_vld    <= s1_vld;
         s2_q      <= s2_d;
         out_valid <= s2_vld;
         res       <= s3_res;
      end
   end

`ifdef SVFLOAT_ADDSUB_FLAGS_EN
   logic    s1_inv_q, s2_inv_q;
   logic    a_snan, b_snan;
   fflags_t fl;

   always_comb begin
      a_snan = a_nan & ~a.man[MW-1];
      b_snan = b_nan & ~b_n.man[MW-1];

      fl = '0;
      if (s2_q.spec) begin
         fl.invalid = s2_inv_q;
      end else begin
         fl.overflow  = ovf;
         fl.inexact   = nm[2] | nm[1] | nm[0] | ovf;
         // Tininess is judged before rounding.
         fl.underflow = ~nm[GW-1] & (nm[2] | nm[1] | nm[0]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_inv_q <= 1'b0;
         s2_inv_q <= 1'b0;
         flags    <= '0;
      end else if (en) begin
         s1_inv_q <= a_snan | b_snan | inf_clash;
         s2_inv_q <= s1_inv_q;
         flags    <= fl;
      end
   end
`endif

endmodule

// File: tb/tb_svfloat_addsub.sv
module tb_svfloat_addsub;
   import svfloat::*;

   typedef struct packed {
      logic [31:0] r;
      logic [4:0]  f;
   } exp_t;

   logic   clk       = 1'b0;
   logic   rst       = 1'b1;
   logic   in_valid  = 1'b0;
   logic   sub       = 1'b0;
   logic   out_ready = 1'b1;
   logic   rdy_cmd   = 1'b1;
   logic   rnd_rdy   = 1'b0;
   logic   in_ready, out_valid;
   float32 a = '0;
   float32 b = '0;
   float32 res;
`ifdef SVFLOAT_ADDSUB_FLAGS_EN
   logic [4:0] flags;
`endif

   exp_t        exp_q[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   int          n_out  = 0;
   logic        held   = 1'b0;
   logic [31:0] held_res = '0;

   // Directed cases: a, b, sub, expected res, expected flags.
   logic [31:0] d_a [11] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h7F800000,
                             32'h7F7FFFFF, 32'h3F800000, 32'h00000001, 32'h7FC00000,
                             32'h7F800001, 32'hFF800000, 32'h3F800000};
   logic [31:0] d_b [11] = '{32'h40000000, 32'h3F800000, 32'h00000000, 32'h7F800000,
                             32'h7F7FFFFF, 32'h33800000, 32'h00000001, 32'h3F800000,
                             32'h00000000, 32'h3F800000, 32'h7F800000};
   logic        d_s [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [31:0] d_r [11] = '{32'h40400000, 32'h00000000, 32'h80000000, 32'h7FC00000,
                             32'h7F800000, 32'h3F800000, 32'h00000002, 32'h7FC00000,
                             32'h7FC00000, 32'hFF800000, 32'hFF800000};
   logic [4:0]  d_f [11] = '{5'b00000, 5'b00000, 5'b00000, 5'b10000, 5'b00101, 5'b00001,
                             5'b00000, 5'b00000, 5'b10000, 5'b00000, 5'b00000};

   // Streamed under back-pressure; all exact.
   logic [31:0] p_a [8] = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h40800000,
                            32'h3FC00000, 32'h3F000000, 32'h3F800000, 32'h41200000};
   logic [31:0] p_b [8] = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F800000,
                            32'h3F000000, 32'h3E800000, 32'h40000000, 32'h40C00000};
   logic        p_s [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [31:0] p_r [8] = '{32'h40400000, 32'h40000000, 32'h40800000, 32'h40400000,
                            32'h40000000, 32'h3F400000, 32'hBF800000, 32'h41800000};

   always #5 clk = ~clk;

   svfloat_addsub dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res)
`ifdef SVFLOAT_ADDSUB_FLAGS_EN
      ,
      .flags     (flags)
`endif
   );

   // out_ready is driven only here, just after the rising edge.
   always @(posedge clk) begin
      #1;
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_cmd;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Scoreboard side: compare every transfer, and check res holds during stalls.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && held) check("res_stable", res, held_res);
      if (!rst && out_valid && out_ready) begin
         check("out_has_expect", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("res#%0d", n_out), res, e.r);
`ifdef SVFLOAT_ADDSUB_FLAGS_EN
            check($sformatf("flags#%0d", n_out), {27'b0, flags}, {27'b0, e.f});
`endif
            n_out++;
         end
      end
      held     = !rst && out_valid && !out_ready;
      held_res = res;
   end

   // Call just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                       input logic [31:0] er, input logic [4:0] ef, input logic push);
      logic acc;
      int   g;
      a        = float32'(ta);
      b        = float32'(tb_v);
      sub      = ts;
      in_valid = 1'b1;
      if (push) exp_q.push_back('{er, ef});
      g = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         g++;
      end while (!acc && g < 200);
      if (!acc) check("send_accept", 32'(acc), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 100) begin
         @(posedge clk);
         #1;
         g++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      // Reset state.
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_res", res, 32'd0);
      @(posedge clk);
      #1;

      // Directed arithmetic, specials, rounding and subnormals, back to back.
      for (int i = 0; i < 11; i++) send(d_a[i], d_b[i], d_s[i], d_r[i], d_f[i], 1'b1);
      drain();

      // Stream under random back-pressure.
      rnd_rdy = 1'b1;
      for (int i = 0; i < 8; i++) send(p_a[i], p_b[i], p_s[i], p_r[i], 5'b00000, 1'b1);
      rnd_rdy = 1'b0;
      rdy_cmd = 1'b1;
      drain();

      // Fill the pipe while stalled, then reset: nothing may come out.
      rdy_cmd = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      for (int i = 0; i < 3; i++) send(p_a[i], p_b[i], p_s[i], p_r[i], 5'b00000, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("flush_out_valid", 32'(out_valid), 32'd0);
      end
      rdy_cmd = 1'b1;
      repeat (2) begin @(posedge clk); #1; end

      // First operation after reset: 1 - 2 = -1, valid on the third edge.
      a        = float32'(32'h3F800000);
      b        = float32'(32'h40000000);
      sub      = 1'b1;
      in_valid = 1'b1;
      exp_q.push_back('{32'hBF800000, 5'b00000});
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("lat_edge1", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_edge2", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_edge3", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/svfloat_addsub.md
# svfloat_addsub

Pipelined floating-point adder/subtractor that directly consumes operand B through an `svfloat_neg` stage. `sub` asserts `neg`, so subtraction becomes addition of a sign-flipped B. The block is a three-stage valid/ready pipeline with full throughput and round-to-nearest-even. It sits between operand fetch and writeback in the svfloat datapath.

## Interface
- `float`, default `svfloat::float32`: floating-point type; exponent/mantissa widths are derived from it.
- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  pipeline accepts operands this cycle.
- `a`, `b`  in  float  operands.
- `sub`  in  1  1 = a − b, 0 = a + b.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `res`  out  float  result.
- `flags`  out  5  {invalid, divzero(0), overflow, underflow, inexact}; present only when `SVFLOAT_ADDSUB_FLAGS_EN` is defined.

## Operation
- Combinational front: `svfloat_neg` with `val=b`, `neg=sub`, `presv_nan=1` gives b'; the pipeline computes a + b'.
- S1, align:
  - Classify each operand as zero, subnormal, normal, inf or NaN.
  - Subnormals use effective exponent 1 and hidden bit 0.
  - Swap so |x| ≥ |y|.
  - Right-shift y's significand by the exponent difference into {guard, round, sticky}. Clamp the shift at mantissa width + 3; every shifted-out bit ORs into sticky.
- S2, add:
  - Same signs: add significands (width = mantissa + 2).
  - Different signs: subtract (no underflow, since x ≥ y). Result sign = x sign.
- S3, normalise and round:
  - Carry-out: shift right 1, exponent + 1.
  - Otherwise left-shift by leading-zero count, limited so the exponent does not go below 1 (this yields a subnormal result).
  - Round to nearest even on guard/round/sticky. A mantissa carry after rounding increments the exponent.
  - Exponent reaching all-ones gives ±inf with overflow.
- Specials, resolved in S1 and carried as a bypass result:
  - Either operand NaN, or inf + (−inf): canonical quiet NaN (sign 0, exponent all-ones, mantissa MSB only). Invalid is raised for a signalling NaN or inf − inf.
  - Single inf: that inf.
  - Exact zero sum from opposite-signed operands: +0.
  - (+0)+(+0) = +0; (−0)+(−0) = −0.

## Timing
- Latency is 3 cycles from the accepting edge to `out_valid`. Throughput is 1 per cycle.
- Global stall: `in_ready = !out_valid || out_ready`. When stalled, all stage registers hold.
- Bubbles are not compressed.
- Transfer occurs on an edge where valid && ready. `res` and `flags` are stable while `out_valid && !out_ready`.
- Reset:
  - All stage valid bits, `out_valid`, `res` and `flags` go to 0.
  - `in_ready` reads 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight operations with no output.
- Simultaneous input accept and output drain in one cycle is required and must not lose or duplicate data.
- `in_valid` with `in_ready = 0`: operands are not sampled; the upstream holds them.

## Configuration
- `SVFLOAT_ADDSUB_FLAGS_EN` defined: the `flags` port exists; flag bits are pipelined alongside the data and valid with `res`.
- Not defined: no `flags` port; the flag logic and its registers are not synthesised. `res` and timing are identical in both builds.

## Structure
- Shared package `svfloat`:
  - float types and `ffunc` classification helpers (existing).
  - New `fflags_t` packed struct for the 5 flags.
  - Function `lzc` for leading-zero count.
- Stage-register structs are local typedefs, because they depend on the `float` parameter.
- Sub-module: exactly one instance of `svfloat_neg` for operand B.

## Test plan
- Add: a=0x3F800000, b=0x40000000, sub=0 → res 0x40400000 after 3 cycles, inexact=0.
- Subtract to zero: a=0x3F800000, b=0x3F800000, sub=1 → 0x00000000; a=0x80000000, b=0x00000000, sub=1 → 0x80000000.
- Specials:
  - a=0x7F800000, b=0x7F800000, sub=1 → 0x7FC00000, invalid=1.
  - a=0x7F7FFFFF, b=0x7F7FFFFF, sub=0 → 0x7F800000, overflow=1, inexact=1.
- Rounding and subnormals:
  - a=0x3F800000, b=0x33800000 (2^-24), sub=0 → 0x3F800000 (tie to even), inexact=1.
  - a=0x00000001, b=0x00000001 → 0x00000002.
- Back-pressure: stream 8 operations with `out_ready` toggled pseudo-randomly → results come out in order and none are lost or duplicated. `res` is stable during every stall.
- Reset with 3 operations in flight → `out_valid` stays 0. The first operation after reset returns the correct result at latency 3.
